// File: rtl/cisr_row_decoder_v2_if.sv
// Bundle of the row decoder's control, row-length handshake and element outputs.
// The master side drives the pass control and the row lengths; the decoder is the slave.
interface cisr_row_decoder_v2_if #(
  parameter int CHAN_NUM = 16,
  parameter int LEN_W    = 32,
  parameter int IDX_W    = 16
);
  logic                      start;
  logic [IDX_W:0]            num_rows;
  logic                      bubble;
  logic [CHAN_NUM*LEN_W-1:0] row_len;
  logic [CHAN_NUM-1:0]       row_len_valid;
  logic [CHAN_NUM-1:0]       row_len_pop;
  logic [CHAN_NUM-1:0]       elem_valid;
  logic [CHAN_NUM*IDX_W-1:0] row_idx_out;
  logic [CHAN_NUM-1:0]       row_last;
  logic [CHAN_NUM-1:0]       row_empty;
  logic                      busy;
  logic                      done;

  modport master (
    output start, num_rows, bubble, row_len, row_len_valid,
    input  row_len_pop, elem_valid, row_idx_out, row_last, row_empty, busy, done
  );

  modport slave (
    input  start, num_rows, bubble, row_len, row_len_valid,
    output row_len_pop, elem_valid, row_idx_out, row_last, row_empty, busy, done
  );
endinterface

// File: rtl/cisr_row_decoder_v2.sv
// CISR row-index decoder: lockstep channels each own one row, emit its index once per
// nonzero, and refill from the row-length buffer in channel-priority order.
module cisr_row_decoder_v2 #(
  parameter int CHAN_NUM = 16,
  parameter int LEN_W    = 32,
  parameter int IDX_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cisr_row_decoder_v2_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [IDX_W:0]   ROW_ONE = (IDX_W+1)'(1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q     [CHAN_NUM];
  logic [LEN_W-1:0]    cnt_d     [CHAN_NUM];
  logic [IDX_W-1:0]    cur_idx_q [CHAN_NUM];
  logic [IDX_W-1:0]    cur_idx_d [CHAN_NUM];
  logic [CHAN_NUM-1:0] empty_pend_q, empty_pend_d;
  logic [IDX_W:0]      next_row_q, next_row_d;
  logic [IDX_W:0]      rows_q, rows_d;

  logic                run;
  logic                fire;
  logic                all_idle;
  logic [CHAN_NUM-1:0] cand;
  logic [CHAN_NUM-1:0] pop;
  logic [IDX_W:0]      rank [CHAN_NUM];
  logic [IDX_W:0]      pop_cnt;
  logic [IDX_W:0]      acc;

  logic [CHAN_NUM-1:0]       elem_valid, row_last, row_empty, row_len_pop;
  logic [CHAN_NUM*IDX_W-1:0] row_idx_out;

  assign run = (state_q == RUN);

  // Candidates are ranked by channel number; only ranks that still map to a row pop.
  always_comb begin
    acc      = '0;
    pop_cnt  = '0;
    all_idle = (empty_pend_q == '0);
    for (int k = 0; k < CHAN_NUM; k++) begin
      cand[k] = run && (cnt_q[k] <= LEN_ONE);
      rank[k] = acc;
      if (cand[k]) acc = acc + ROW_ONE;
      pop[k] = cand[k] && ((next_row_q + rank[k]) < rows_q);
      if (pop[k]) pop_cnt = pop_cnt + ROW_ONE;
      if (cnt_q[k] != '0) all_idle = 1'b0;
    end
    fire = run && !bus.bubble && ((pop & ~bus.row_len_valid) == '0);
  end

  always_comb begin
    elem_valid  = '0;
    row_last    = '0;
    row_empty   = '0;
    row_idx_out = '0;
    for (int k = 0; k < CHAN_NUM; k++) begin
      elem_valid[k] = fire && (cnt_q[k] != '0);
      row_last[k]   = elem_valid[k] && (cnt_q[k] == LEN_ONE);
      row_empty[k]  = fire && empty_pend_q[k];
      row_idx_out[k*IDX_W +: IDX_W] = cur_idx_q[k];
    end
    row_len_pop = fire ? pop : '0;
  end

  assign bus.elem_valid  = elem_valid;
  assign bus.row_last    = row_last;
  assign bus.row_empty   = row_empty;
  assign bus.row_len_pop = row_len_pop;
  assign bus.row_idx_out = row_idx_out;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

  always_comb begin
    logic [IDX_W:0]   idx_sum;
    logic [LEN_W-1:0] len_k;
    state_d      = state_q;
    rows_d       = rows_q;
    next_row_d   = next_row_q;
    cnt_d        = cnt_q;
    cur_idx_d    = cur_idx_q;
    empty_pend_d = empty_pend_q;
    idx_sum      = '0;
    len_k        = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = RUN;
          rows_d       = bus.num_rows;
          next_row_d   = '0;
          empty_pend_d = '0;
          for (int k = 0; k < CHAN_NUM; k++) cnt_d[k] = '0;
        end
      end
      RUN: begin
        if ((next_row_q == rows_q) && all_idle) state_d = DONE;
        // A zero-length row leaves cnt at 0, so the channel is a candidate again next fire.
        if (fire) begin
          next_row_d = next_row_q + pop_cnt;
          for (int k = 0; k < CHAN_NUM; k++) begin
            len_k   = bus.row_len[k*LEN_W +: LEN_W];
            idx_sum = next_row_q + rank[k];
            if (pop[k]) begin
              cnt_d[k]        = len_k;
              cur_idx_d[k]    = idx_sum[IDX_W-1:0];
              empty_pend_d[k] = (len_k == '0);
            end else if (cnt_q[k] != '0) begin
              cnt_d[k]        = cnt_q[k] - LEN_ONE;
              empty_pend_d[k] = 1'b0;
            end else begin
              empty_pend_d[k] = 1'b0;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      empty_pend_q <= '0;
      next_row_q   <= '0;
      rows_q       <= '0;
      for (int k = 0; k < CHAN_NUM; k++) begin
        cnt_q[k]     <= '0;
        cur_idx_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      empty_pend_q <= empty_pend_d;
      next_row_q   <= next_row_d;
      rows_q       <= rows_d;
      for (int k = 0; k < CHAN_NUM; k++) begin
        cnt_q[k]     <= cnt_d[k];
        cur_idx_q[k] <= cur_idx_d[k];
      end
    end
  end
endmodule

// File: doc/cisr_row_decoder_v2.md
Name: cisr_row_decoder_v2

Overview:
- Parametrised CISR row-index decoder for the SpMV datapath.
- Sits between the row-length buffer and the per-channel multiply/accumulate lanes.
- All channels advance in lockstep. Each channel owns one matrix row at a time and emits that row's index once per nonzero element.
- When a channel finishes its row, it pulls a fresh row length and is assigned the next global row index in channel-priority order.
- New versus the previous decoder: start/done control, a bounded row count, zero-length-row handling, a per-channel row-length valid handshake, and row_last/row_empty markers.

Parameters:
- CHAN_NUM, 16, number of lockstep channels (≥2).
- LEN_W, 32, row-length width.
- IDX_W, 16, row-index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pass. Ignored unless in IDLE.
- num_rows  in  IDX_W+1  total rows in the pass. Sampled on start.
- bubble  in  1  global stall. No channel advances while high.
- row_len  in  CHAN_NUM*LEN_W  per-channel next row length. Channel k occupies bits [k*LEN_W +: LEN_W].
- row_len_valid  in  CHAN_NUM  per-channel row_len valid.
- row_len_pop  out  CHAN_NUM  channel k consumed row_len[k] this cycle.
- elem_valid  out  CHAN_NUM  channel k emits one element this cycle.
- row_idx_out  out  CHAN_NUM*IDX_W  current row index per channel.
- row_last  out  CHAN_NUM  the element emitted this cycle is the last of its row.
- row_empty  out  CHAN_NUM  a zero-length row (index on row_idx_out) completes this cycle.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse at the end of the pass.

Behaviour:
- Reset is asynchronous, active-high, and applies immediately.
  - State goes to IDLE.
  - Every cnt[k], cur_idx[k], empty_pend[k], next_row and rows_r clears to 0.
  - Every output reads 0.
- State machine:
  - IDLE → RUN on start. At that edge: rows_r <= num_rows, next_row <= 0, all cnt/empty_pend <= 0.
  - RUN → DONE when next_row == rows_r and all cnt == 0 and no empty_pend.
  - DONE → IDLE unconditionally. done = (state == DONE).
- Pop candidacy:
  - cand[k] = RUN && (cnt[k] ≤ 1).
  - rank[k] = number of cand[j] with j < k.
  - pop[k] = cand[k] && (next_row + rank[k] < rows_r).
- Fire condition:
  - fire = RUN && !bubble && every popping channel has row_len_valid[k] high.
  - row_len_pop[k] = fire && pop[k].
- Element outputs (combinational from registered state plus fire):
  - elem_valid[k] = fire && cnt[k] != 0.
  - row_last[k] = elem_valid[k] && cnt[k] == 1.
  - row_empty[k] = fire && empty_pend[k].
  - row_idx_out[k] = cur_idx[k].
- On fire, channel k updates as follows:
  - If pop[k]: cnt <= row_len[k], cur_idx <= next_row + rank[k], empty_pend <= (row_len[k] == 0).
  - Else if cnt != 0: cnt <= cnt − 1 and empty_pend <= 0.
  - Otherwise: empty_pend <= 0.
- next_row advances by popcount(pop) on fire.
- Zero-stall continuation: a channel emitting its last element (cnt == 1) pops in the same cycle, so its next row's first element appears on the following fire.
- Zero-length row:
  - The index is consumed and no elements are emitted.
  - row_empty pulses on the next fire with that index.
  - The channel, now at cnt == 0, pops again on that same fire.
- Row exhaustion: candidates whose rank reaches beyond the remaining rows do not pop, stay at cnt 0, and idle.
- Stalls: with bubble high or any popping channel invalid, all registers hold and elem_valid, row_last, row_empty and row_len_pop are all 0.
- rows_r == 0 at start: RUN lasts one cycle, then DONE.
- start while in RUN or DONE is ignored.
- Arithmetic:
  - next_row and the index sums are IDX_W+1 bits wide.
  - cur_idx stores the low IDX_W bits.
  - cnt never underflows.

Test Plan:
1. Basic pass.
   - Setup: CHAN_NUM=4, num_rows=4, first-fire row_len {2,1,3,1}, all valid.
   - Fire 1: pops all channels; cur_idx = 0,1,2,3.
   - Fire 2: elem_valid = 1111; row_last on ch1 and ch3; no pops since next_row = 4.
   - Fire 3: ch0 last, ch2 mid-row.
   - Fire 4: ch2 last.
   - Then the done pulse, then busy = 0.
2. Priority ordering.
   - Setup: num_rows=8, all lengths 1.
   - Fire 1 assigns 0–3; fire 2 assigns 4–7 in channel order while all channels emit with row_last.
   - Fire 3 emits rows 4–7; done follows.
3. Zero-length row.
   - Setup: ch0's first length is 0, num_rows=5, others length 2.
   - Fire 2: row_empty[0] = 1 with idx 0; ch0 pops and receives idx 4.
   - Fire 3: ch0 emits idx 4.
4. Bubble hold.
   - Setup: ch2 mid-row with cnt = 3; bubble held 3 cycles.
   - During the bubble: no elem_valid, no pops, cnt stays 3.
   - After release: emission resumes with the same idx.
5. Handshake stall.
   - Setup: ch1 popping with row_len_valid[1] = 0.
   - While invalid: no channel fires and next_row is unchanged.
   - When valid rises: all pops and emissions occur together.
6. Reset and zero-row pass.
   - rst asserted mid-RUN: outputs go 0 asynchronously and the block returns to IDLE.
   - start with num_rows=0: busy for 1 cycle, then done, with no pops.
